lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 write engine: latches {rs,data}, then SETUP -> EN pulse -> HOLD -> exec WAIT.
// Latency: RS/DATA valid 1 cycle after accept; ready returns SETUP+PULSE+HOLD+wait cycles later.
// Backpressure: ready_o low while busy; requests seen then are dropped. Optional LCD_INIT_EN adds power-up init.
module lcd_ctrl #(
   parameter int unsigned SETUP_CYC     = 2,
   parameter int unsigned PULSE_CYC     = 12,
   parameter int unsigned HOLD_CYC      = 2,
   parameter int unsigned EXEC_CYC      = 2000,
   parameter int unsigned LONG_EXEC_CYC = 80000,
   parameter int unsigned POWERUP_CYC   = 2000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic [8:0]  wdata_i,
   output logic        ready_o,
   output logic [31:0] status_o,
   output logic        lcd_on_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic [7:0]  lcd_data_o
);

   localparam int unsigned MAX_CYC = (LONG_EXEC_CYC > POWERUP_CYC) ? LONG_EXEC_CYC : POWERUP_CYC;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
`ifdef LCD_INIT_EN
      , S_PWR
`endif
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          busy;
   logic          init_done;
   logic          long_cmd;

`ifdef LCD_INIT_EN
   logic [2:0]    init_step;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd1:    init_cmd = 8'h38;
         3'd2:    init_cmd = 8'h0C;
         3'd3:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
   endfunction
`endif

   // clear (0x01) and home (0x02/0x03) need the long execution wait
   assign long_cmd = !lcd_rs_o && (lcd_data_o inside {8'h01, 8'h02, 8'h03});
   assign lcd_rw_o = 1'b0;
   assign status_o = {30'b0, init_done, busy};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         cnt        <= '0;
         busy       <= 1'b0;
         init_done  <= 1'b0;
         ready_o    <= 1'b0;
         lcd_on_o   <= 1'b0;
         lcd_rs_o   <= 1'b0;
         lcd_en_o   <= 1'b0;
         lcd_data_o <= 8'h00;
`ifdef LCD_INIT_EN
         init_step  <= 3'd0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
`ifdef LCD_INIT_EN
               if (!init_done) begin
                  if (init_step == 3'd0) begin
                     state     <= S_PWR;
                     cnt       <= CW'(POWERUP_CYC - 1);
                     lcd_on_o  <= 1'b1;
                     busy      <= 1'b1;
                     init_step <= 3'd1;
                  end else if (init_step <= 3'd4) begin
                     lcd_rs_o   <= 1'b0;
                     lcd_data_o <= init_cmd(init_step);
                     state      <= S_SETUP;
                     cnt        <= CW'(SETUP_CYC - 1);
                     init_step  <= init_step + 3'd1;
                  end else begin
                     init_done <= 1'b1;
                     ready_o   <= 1'b1;
                     busy      <= 1'b0;
                  end
               end else
`else
               init_done <= 1'b1;
               lcd_on_o  <= 1'b1;
`endif
               if (ready_o && req_i) begin
                  lcd_rs_o   <= wdata_i[8];
                  lcd_data_o <= wdata_i[7:0];
                  state      <= S_SETUP;
                  cnt        <= CW'(SETUP_CYC - 1);
                  ready_o    <= 1'b0;
                  busy       <= 1'b1;
               end else begin
                  ready_o <= 1'b1;
                  busy    <= 1'b0;
               end
            end
`ifdef LCD_INIT_EN
            S_PWR: begin
               if (cnt == '0) state <= S_IDLE;
               else           cnt   <= cnt - CW'(1);
            end
`endif
            S_SETUP: begin
               if (cnt == '0) begin
                  state    <= S_PULSE;
                  cnt      <= CW'(PULSE_CYC - 1);
                  lcd_en_o <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_PULSE: begin
               if (cnt == '0) begin
                  state    <= S_HOLD;
                  cnt      <= CW'(HOLD_CYC - 1);
                  lcd_en_o <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  state <= S_WAIT;
                  cnt   <= long_cmd ? CW'(LONG_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_WAIT: begin
               // raise ready on the same edge as the return to IDLE so the
               // busy window is exactly the sum of the phase lengths
               if (cnt == '0) begin
                  state   <= S_IDLE;
                  ready_o <= init_done;
                  busy    <= !init_done;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: per-cycle reference model plus directed literal checks.
module tb_lcd_ctrl;
   localparam int S = 1, P = 4, H = 1, E = 8, L = 20, PW = 10;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic [8:0]  wdata_i = 9'h000;
   logic        ready_o, lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o;
   logic [31:0] status_o;
   logic [7:0]  lcd_data_o;

   always #5 clk = ~clk;

   lcd_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(E),
              .LONG_EXEC_CYC(L), .POWERUP_CYC(PW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .wdata_i(wdata_i),
      .ready_o(ready_o), .status_o(status_o), .lcd_on_o(lcd_on_o),
      .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o),
      .lcd_data_o(lcd_data_o));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired at t=%0t", name, $time);
   endtask

   // Reference model: "age" = cycles since acceptance, transfer length from the phase sums.
   int          age = -1;
   int          tlen = 0;
   logic        m_rdy = 1'b0, m_en = 1'b0, m_rs = 1'b0, m_on = 1'b0, m_init = 1'b0;
   logic [7:0]  m_data = 8'h00;

   always @(posedge clk) begin
      if (!rst_ni) begin
         age = -1; m_rdy = 1'b0; m_en = 1'b0; m_rs = 1'b0;
         m_data = 8'h00; m_on = 1'b0; m_init = 1'b0;
      end else begin
         if (m_rdy && req_i) begin
            m_rs   = wdata_i[8];
            m_data = wdata_i[7:0];
            age    = 1;
            tlen   = S + P + H + ((!wdata_i[8] && wdata_i[7:0] >= 8'd1 && wdata_i[7:0] <= 8'd3) ? L : E);
         end else if (age >= 0) begin
            age++;
         end
         if (age > tlen) age = -1;
         m_on = 1'b1; m_init = 1'b1;
         m_rdy = (age < 0);
         m_en  = (age >= S + 1) && (age <= S + P);
      end
   end

`ifndef LCD_INIT_EN
   always @(negedge clk) begin
      check("ready", {31'b0, ready_o}, {31'b0, m_rdy});
      check("en",    {31'b0, lcd_en_o}, {31'b0, m_en});
      check("rs",    {31'b0, lcd_rs_o}, {31'b0, m_rs});
      check("rw",    {31'b0, lcd_rw_o}, 32'd0);
      check("data",  {24'b0, lcd_data_o}, {24'b0, m_data});
      check("on",    {31'b0, lcd_on_o}, {31'b0, m_on});
      check("status", status_o, {30'b0, m_init, m_init & ~m_rdy});
   end
`endif

   task automatic wait_ready(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (ready_o) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) timeout("wait_ready");
   endtask

   // One transfer; observes 40 cycles after acceptance (i=1 is cycle k+1).
   task automatic xfer(input logic [8:0] w, input bit second,
                       output int rlo, output int en_hi, output int en_rise,
                       output int first_en, output logic [31:0] st_busy,
                       output logic [31:0] st_after);
      bit ok;
      logic prev;
      rlo = 0; en_hi = 0; en_rise = 0; first_en = -1; prev = 1'b0;
      st_busy = '0;
      wait_ready(200, ok);
      req_i = 1'b1; wdata_i = w;
      @(negedge clk);
      req_i = 1'b0; wdata_i = 9'($urandom);
      for (int i = 1; i <= 40; i++) begin
         if (!ready_o) rlo++;
         if (lcd_en_o) en_hi++;
         if (lcd_en_o && !prev) en_rise++;
         if (lcd_en_o && first_en < 0) first_en = i;
         if (i == 1) st_busy = status_o;
         prev = lcd_en_o;
         if (second && i == 4) begin req_i = 1'b1; wdata_i = 9'h142; end
         if (second && i == 5) req_i = 1'b0;
         @(negedge clk);
      end
      st_after = status_o;
   endtask

   initial begin
      int rlo, en_hi, en_rise, first_en;
      logic [31:0] st_busy, st_after;
      bit ok;
      rst_ni = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready",  {31'b0, ready_o}, 32'd0);
      check("rst_status", status_o, 32'd0);
      check("rst_en",     {31'b0, lcd_en_o}, 32'd0);
      check("rst_data",   {24'b0, lcd_data_o}, 32'd0);
      check("rst_on",     {31'b0, lcd_on_o}, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk);
`ifdef LCD_INIT_EN
      begin
         logic [7:0] got [4];
         logic [7:0] want [4];
         int n, t;
         logic prev;
         want[0] = 8'h38; want[1] = 8'h0C; want[2] = 8'h01; want[3] = 8'h06;
         n = 0; t = 1; prev = 1'b0; first_en = -1;
         check("init_on",     {31'b0, lcd_on_o}, 32'd1);
         check("init_status", status_o, 32'd1);
         while (!ready_o && t < 3000) begin
            if (lcd_en_o && !prev) begin
               if (n < 4) got[n] = lcd_data_o;
               if (first_en < 0) first_en = t;
               n++;
            end
            prev = lcd_en_o;
            @(negedge clk);
            t++;
         end
         if (!ready_o) timeout("init_ready");
         check("init_pulses", n, 4);
         check("init_delay", {31'b0, first_en > PW}, 32'd1);
         for (int i = 0; i < 4; i++) check("init_cmd", {24'b0, got[i]}, {24'b0, want[i]});
         check("init_done_status", status_o, 32'd2);
      end
`else
      check("rel_ready",  {31'b0, ready_o}, 32'd1);
      check("rel_on",     {31'b0, lcd_on_o}, 32'd1);
      check("rel_status", status_o, 32'd2);

      xfer(9'h141, 1'b0, rlo, en_hi, en_rise, first_en, st_busy, st_after);
      check("a_ready_low", rlo, 14);
      check("a_en_width",  en_hi, 4);
      check("a_en_first",  first_en, 2);
      check("a_data",      {24'b0, lcd_data_o}, 32'h41);
      check("a_rs",        {31'b0, lcd_rs_o}, 32'd1);
      check("a_st_busy",   st_busy, 32'h3);
      check("a_st_after",  st_after, 32'h2);

      xfer(9'h001, 1'b0, rlo, en_hi, en_rise, first_en, st_busy, st_after);
      check("clr_ready_low", rlo, 26);
      check("clr_en_width",  en_hi, 4);
      check("clr_st_busy",   st_busy, 32'h3);
      check("clr_st_after",  st_after, 32'h2);

      xfer(9'h141, 1'b1, rlo, en_hi, en_rise, first_en, st_busy, st_after);
      check("ign_data",  {24'b0, lcd_data_o}, 32'h41);
      check("ign_pulses", en_rise, 1);

      wait_ready(200, ok);
      req_i = 1'b1; wdata_i = 9'h141;
      @(negedge clk);
      req_i = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (lcd_en_o) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) timeout("wait_en");
      rst_ni = 1'b0;
      @(negedge clk);
      check("mid_rst_en",     {31'b0, lcd_en_o}, 32'd0);
      check("mid_rst_data",   {24'b0, lcd_data_o}, 32'd0);
      check("mid_rst_ready",  {31'b0, ready_o}, 32'd0);
      check("mid_rst_status", status_o, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk);
      check("mid_rel_ready", {31'b0, ready_o}, 32'd1);
      repeat (10) begin
         check("no_resume_en", {31'b0, lcd_en_o}, 32'd0);
         @(negedge clk);
      end

      for (int c = 0; c < 4000; c++) begin
         rst_ni = ($urandom_range(0, 599) != 0);
         req_i  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) wdata_i = {1'b0, 8'($urandom_range(0, 4))};
         else                           wdata_i = 9'($urandom);
         @(negedge clk);
      end
      req_i = 1'b0; rst_ni = 1'b1;
      repeat (3) @(negedge clk);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
